bcd_mult3_gen: RTL

Sequential generator of 4-digit packed-BCD values that are multiples of 3. It produces the values a divisibility-by-3 checker consumes. The generator aligns a loaded start value up to the next multiple of 3, then emits an ascending stream in steps of 3 with BCD carry, up to 9999. Output uses a valid/ready handshake, so a downstream checker or display path can apply backpressure.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_mult3_gen_if.sv | 14 +
 rtl/bcd_add_small.sv | 35 +++
 rtl/bcd_mult3_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the multiple-of-3 BCD generator.
//   state_e      : controller states
//   BCD_MAX      : last value of a run (9999 is itself a multiple of 3)
//   DIGIT_W      : bits per packed-BCD digit
//   bcd_digit_ok : true when a 4-bit field is a legal decimal digit
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      RUN,
      DONE
   } state_e;

   localparam logic [15:0] BCD_MAX = 16'h9999;
   localparam int          DIGIT_W = 4;

   function automatic logic bcd_digit_ok(input logic [DIGIT_W-1:0] digit);
      return digit <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_mult3_gen_if.sv
// Output stream of the generator: valid/ready handshake carrying one packed-BCD value.
//   out_valid : producer has a value on out_bcd
//   out_ready : consumer accepts out_bcd when high together with out_valid
//   out_bcd   : 4-digit packed BCD value
//   out_last  : out_bcd is the final value 9999
interface bcd_mult3_gen_if;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic        out_last;

   modport master (output out_valid, output out_bcd, output out_last, input  out_ready);
   modport slave  (input  out_valid, input  out_bcd, input  out_last, output out_ready);
endinterface

// File: rtl/bcd_add_small.sv
// Combinational 4-digit packed-BCD adder for a small increment (0..3).
//   a   : packed BCD operand, every digit <= 9
//   inc : increment added to the least significant digit
//   sum : packed BCD result; carry out of the top digit is dropped
module bcd_add_small
   import bcd_pkg::*;
(
   input  logic [15:0] a,
   input  logic [1:0]  inc,
   output logic [15:0] sum
);

   logic [DIGIT_W:0] digit_tmp;
   logic             carry;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      sum       = '0;
      carry     = 1'b0;
      digit_tmp = '0;
      for (int i = 0; i < 4; i++) begin
         // The increment enters digit 0; higher digits only see the ripple carry.
         digit_tmp = {1'b0, a[i*DIGIT_W +: DIGIT_W]}
                   + ((i == 0) ? {3'b000, inc} : {4'b0000, carry});
         if (digit_tmp > 5'd9) begin
            sum[i*DIGIT_W +: DIGIT_W] = 4'(digit_tmp - 5'd10);
            carry                     = 1'b1;
         end else begin
            sum[i*DIGIT_W +: DIGIT_W] = digit_tmp[DIGIT_W-1:0];
            carry                     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/bcd_mult3_gen.sv
// Generator of ascending 4-digit packed-BCD multiples of 3.
// A start value is aligned up to the next multiple of 3, then values are
// streamed in steps of 3 up to 9999 over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (sampled only in IDLE), start_val loaded with it
//   abort      : synchronous cancel, highest priority
//   busy       : high while aligning or streaming
//   done       : one-cycle pulse after 9999 has been accepted
//   err        : one-cycle pulse when start_val held a non-decimal digit
//   ob         : output stream (master side)
module bcd_mult3_gen
   import bcd_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [15:0]        start_val,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               err,
   bcd_mult3_gen_if.master    ob
);

   state_e      state_q, state_d;
   logic [15:0] value_q, value_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        start_ok;
   logic [5:0]  digit_sum;
   logic [5:0]  rem3;
   logic [1:0]  align_inc;
   logic [1:0]  add_inc;
   logic [15:0] add_sum;

   assign start_ok = bcd_digit_ok(start_val[3:0])  & bcd_digit_ok(start_val[7:4])
                   & bcd_digit_ok(start_val[11:8]) & bcd_digit_ok(start_val[15:12]);

   // A decimal number and its digit sum share the same remainder mod 3.
   assign digit_sum = {2'b00, value_q[3:0]}  + {2'b00, value_q[7:4]}
                    + {2'b00, value_q[11:8]} + {2'b00, value_q[15:12]};
   assign rem3      = digit_sum % 6'd3;
   assign align_inc = (rem3 == 6'd0) ? 2'd0 : 2'(6'd3 - rem3);

   // One adder serves both the alignment step and the streaming step.
   assign add_inc = (state_q == ALIGN) ? align_inc : 2'd3;

   bcd_add_small u_add (
      .a   (value_q),
      .inc (add_inc),
      .sum (add_sum)
   );

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      err_d   = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     value_d = start_val;
                     state_d = ALIGN;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ALIGN: begin
               value_d = add_sum;
               state_d = RUN;
            end
            RUN: begin
               // In RUN out_valid_q is always set, so out_ready alone marks a handshake.
               if (ob.out_ready) begin
                  if (value_q == BCD_MAX) state_d = DONE;
                  else                    value_d = add_sum;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      out_valid_d = (state_d == RUN);
      out_last_d  = (state_d == RUN) && (value_d == BCD_MAX);
      busy_d      = (state_d == ALIGN) || (state_d == RUN);
      done_d      = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         value_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         value_q     <= value_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ob.out_valid = out_valid_q;
   assign ob.out_bcd   = value_q;
   assign ob.out_last  = out_last_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule
